// File: rtl/uart_cmd_engine.sv
`default_nettype none
// uart_cmd_engine: byte-stream command decoder driving per-channel AXI generator
// and PMU controls; every command answers with optional data bytes, then one status byte.
module uart_cmd_engine #(
  parameter int CORE_COUNT     = 16,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int PMU_ADDR_WIDTH = 5,
  parameter int PMU_DATA_BYTES = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                          clk_i,
  input  logic                                          arstn_i,
  input  logic [7:0]                                    rx_data_i,
  input  logic                                          rx_valid_i,
  output logic [7:0]                                    tx_data_o,
  output logic                                          tx_valid_o,
  input  logic                                          tx_ready_i,
  output logic [CORE_COUNT-1:0][PMU_ADDR_WIDTH-1:0]     pmu_addr_o,
  input  logic [CORE_COUNT-1:0][8*PMU_DATA_BYTES-1:0]   pmu_data_i,
  output logic [7:0]                                    req_depth_o,
  output logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0]       id_o,
  output logic [CORE_COUNT-1:0][7:0]                    axlen_o,
  output logic [CORE_COUNT-1:0]                         write_o,
  output logic [CORE_COUNT-1:0]                         fifo_push_o,
  output logic                                          start_o,
  input  logic [CORE_COUNT-1:0]                         idle_i,
  output logic                                          busy_o
);

  localparam int CIW        = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int CORE_BYTES = (CIW + 7) / 8;
  localparam int ID_BYTES   = (AXI_ID_WIDTH + 7) / 8;
  localparam int IDLE_BYTES = (CORE_COUNT + 7) / 8;
  localparam int CBW        = 8 * CORE_BYTES;
  localparam int MAXA       = CORE_BYTES + ID_BYTES + 1;
  localparam int ACW        = $clog2(MAXA + 1);
  localparam int DB         = (PMU_DATA_BYTES > IDLE_BYTES) ? PMU_DATA_BYTES : IDLE_BYTES;
  localparam int DBW        = 8 * DB;
  localparam int DCW        = $clog2(DB + 1);
  localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_ECHO   = 8'h01;
  localparam logic [7:0] OP_DEPTH  = 8'h02;
  localparam logic [7:0] OP_RD     = 8'h03;
  localparam logic [7:0] OP_WR     = 8'h04;
  localparam logic [7:0] OP_ISTAT  = 8'h05;
  localparam logic [7:0] OP_START  = 8'h06;
  localparam logic [7:0] OP_PMU    = 8'h07;
  localparam logic [7:0] OP_STATUS = 8'h08;

  typedef enum logic [2:0] {S_IDLE, S_ARGS, S_EXEC, S_DATA, S_STAT} state_t;

  state_t                                   r_state, w_nxt;
  logic [7:0]                               w_code;
  logic [7:0]                               r_op;
  logic [7:0]                               r_args [MAXA];
  logic [ACW-1:0]                           r_acnt;
  logic [TW-1:0]                            r_tcnt;
  logic [1:0]                               r_phase;
  logic [DBW-1:0]                           r_dbuf;
  logic [DCW-1:0]                           r_dcnt;
  logic [7:0]                               r_code;
  logic                                     r_err;
  logic [3:0]                               r_last;
  logic [CORE_COUNT-1:0][PMU_ADDR_WIDTH-1:0] r_pmu_addr;
  logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0]  r_id;
  logic [CORE_COUNT-1:0][7:0]               r_len;
  logic [CORE_COUNT-1:0]                    r_wr;
  logic [CORE_COUNT-1:0]                    r_push;
  logic [7:0]                               r_depth;
  logic                                     r_start;

  logic [CBW-1:0]          w_core;
  logic [8*ID_BYTES-1:0]   w_id_raw;
  logic [CIW-1:0]          w_cidx;
  logic                    w_bad;
  logic                    w_tmo;
  logic [7:0]              w_echo;
  logic [ACW-1:0]          w_nargs_rx;
  logic [ACW-1:0]          w_nargs_op;

  function automatic logic [ACW-1:0] f_nargs(input logic [7:0] op);
    case (op)
      OP_ECHO, OP_DEPTH: f_nargs = ACW'(1);
      OP_RD, OP_WR:      f_nargs = ACW'(MAXA);
      OP_PMU:            f_nargs = ACW'(CORE_BYTES + 1);
      default:           f_nargs = '0;
    endcase
  endfunction

  // Argument fields are little-endian; the full core field is kept for the range check.
  always_comb begin
    w_core   = '0;
    w_id_raw = '0;
    for (int b = 0; b < CORE_BYTES; b++) w_core[8*b +: 8] = r_args[b];
    for (int b = 0; b < ID_BYTES; b++) w_id_raw[8*b +: 8] = r_args[CORE_BYTES + b];
  end

  assign w_cidx     = w_core[CIW-1:0];
  assign w_bad      = (32'(w_core) >= 32'(CORE_COUNT));
  assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_tcnt == TMAX);
  assign w_echo     = r_args[0] + 8'd1;
  assign w_nargs_rx = f_nargs(rx_data_i);
  assign w_nargs_op = f_nargs(r_op);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_code = 8'h00;
    case (r_state)
      S_IDLE: if (rx_valid_i) begin
        if (rx_data_i < OP_ECHO || rx_data_i > OP_STATUS) begin
          w_nxt  = S_STAT;
          w_code = 8'hE1;
        end else if (w_nargs_rx == '0) w_nxt = S_EXEC;
        else                           w_nxt = S_ARGS;
      end
      S_ARGS: begin
        if (rx_valid_i) begin
          if ((r_acnt + ACW'(1)) == w_nargs_op) w_nxt = S_EXEC;
        end else if (w_tmo) begin
          w_nxt  = S_STAT;
          w_code = 8'hE3;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_ECHO, OP_ISTAT, OP_STATUS: w_nxt = S_DATA;
          OP_DEPTH: w_nxt = S_STAT;
          OP_START: if (r_phase == 2'd1) w_nxt = S_STAT;
          OP_RD, OP_WR, OP_PMU: begin
            if (w_bad) begin
              w_nxt  = S_STAT;
              w_code = 8'hE2;
            end else if (r_phase == 2'd2) begin
              w_nxt = (r_op == OP_PMU) ? S_DATA : S_STAT;
            end
          end
          default: begin
            w_nxt  = S_STAT;
            w_code = 8'hE1;
          end
        endcase
      end
      S_DATA: if (tx_ready_i && r_dcnt == DCW'(1)) w_nxt = S_STAT;
      S_STAT: if (tx_ready_i) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_op       <= '0;
      r_acnt     <= '0;
      r_tcnt     <= '0;
      r_phase    <= '0;
      r_dbuf     <= '0;
      r_dcnt     <= '0;
      r_code     <= '0;
      r_err      <= 1'b0;
      r_last     <= '0;
      r_pmu_addr <= '0;
      r_id       <= '0;
      r_len      <= '0;
      r_wr       <= '0;
      r_push     <= '0;
      r_depth    <= '0;
      r_start    <= 1'b0;
      for (int i = 0; i < MAXA; i++) r_args[i] <= '0;
    end else begin
      r_push  <= '0;
      r_start <= 1'b0;
      r_phase <= (r_state == S_EXEC) ? r_phase + 2'd1 : 2'd0;
      if (r_state != S_STAT && w_nxt == S_STAT) begin
        r_code <= w_code;
        r_last <= w_code[3:0];
        if (w_code != 8'h00) r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (rx_valid_i) begin
          r_op   <= rx_data_i;
          r_acnt <= '0;
          r_tcnt <= '0;
        end
        S_ARGS: begin
          if (rx_valid_i) begin
            r_args[r_acnt] <= rx_data_i;
            r_acnt         <= r_acnt + ACW'(1);
            r_tcnt         <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_EXEC: begin
          if (r_phase == 2'd0) begin
            case (r_op)
              OP_ECHO: begin
                r_dbuf <= DBW'(w_echo);
                r_dcnt <= DCW'(1);
              end
              OP_ISTAT: begin
                r_dbuf <= DBW'(idle_i);
                r_dcnt <= DCW'(IDLE_BYTES);
              end
              OP_STATUS: begin
                r_dbuf <= DBW'({r_err, 3'b000, r_last});
                r_dcnt <= DCW'(1);
                r_err  <= 1'b0;
              end
              OP_DEPTH: r_depth <= r_args[0];
              OP_START: r_start <= 1'b1;
              OP_RD, OP_WR: if (!w_bad) begin
                r_id[w_cidx]  <= w_id_raw[AXI_ID_WIDTH-1:0];
                r_len[w_cidx] <= r_args[CORE_BYTES + ID_BYTES];
                r_wr[w_cidx]  <= (r_op == OP_WR);
              end
              OP_PMU: if (!w_bad) r_pmu_addr[w_cidx] <= r_args[CORE_BYTES][PMU_ADDR_WIDTH-1:0];
              default: ;
            endcase
          end else if (r_phase == 2'd1) begin
            // Push fires only after the new channel fields are already on the outputs.
            if (r_op == OP_RD || r_op == OP_WR) r_push[w_cidx] <= 1'b1;
          end else if (r_op == OP_PMU) begin
            r_dbuf <= DBW'(pmu_data_i[w_cidx]);
            r_dcnt <= DCW'(PMU_DATA_BYTES);
          end
        end
        S_DATA: if (tx_ready_i) begin
          r_dbuf <= r_dbuf >> 8;
          r_dcnt <= r_dcnt - DCW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign tx_valid_o  = (r_state == S_DATA) || (r_state == S_STAT);
  assign tx_data_o   = (r_state == S_DATA) ? r_dbuf[7:0] :
                       (r_state == S_STAT) ? r_code : 8'h00;
  assign pmu_addr_o  = r_pmu_addr;
  assign id_o        = r_id;
  assign axlen_o     = r_len;
  assign write_o     = r_wr;
  assign fifo_push_o = r_push;
  assign req_depth_o = r_depth;
  assign start_o     = r_start;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
`default_nettype none
// tb_uart_cmd_engine: directed self-checking bench for the UART command engine.
module tb_uart_cmd_engine;

  localparam int CC = 16;

  logic                 clk_i = 1'b0;
  logic                 arstn_i = 1'b0;
  logic [7:0]           rx_data_i = 8'h00;
  logic                 rx_valid_i = 1'b0;
  logic [7:0]           tx_data_o;
  logic                 tx_valid_o;
  logic                 tx_ready_i = 1'b1;
  logic [CC-1:0][4:0]   pmu_addr_o;
  logic [CC-1:0][63:0]  pmu_data_i = '0;
  logic [7:0]           req_depth_o;
  logic [CC-1:0][4:0]   id_o;
  logic [CC-1:0][7:0]   axlen_o;
  logic [CC-1:0]        write_o;
  logic [CC-1:0]        fifo_push_o;
  logic                 start_o;
  logic [CC-1:0]        idle_i = '0;
  logic                 busy_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  int push_cnt[CC];
  int start_cnt = 0;
  logic [4:0] push_id3 = '0;

  uart_cmd_engine #(
    .CORE_COUNT(CC), .AXI_ID_WIDTH(5), .PMU_ADDR_WIDTH(5),
    .PMU_DATA_BYTES(8), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
    .req_depth_o(req_depth_o), .id_o(id_o), .axlen_o(axlen_o),
    .write_o(write_o), .fifo_push_o(fifo_push_o), .start_o(start_o),
    .idle_i(idle_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial for (int i = 0; i < CC; i++) push_cnt[i] = 0;

  // Transfer / strobe monitor: values seen here are the pre-edge ones.
  always @(posedge clk_i) begin
    if (arstn_i) begin
      if (tx_valid_o && tx_ready_i) q.push_back(tx_data_o);
      for (int i = 0; i < CC; i++) if (fifo_push_o[i]) push_cnt[i]++;
      if (fifo_push_o[3]) push_id3 = id_o[3];
      if (start_o) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n);
    for (int c = 0; c < 2000 && q.size() < n; c++) @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    check(tag, 64'(q.size()), 64'(n));
  endtask

  task automatic exp_tx(input string tag, input int idx, input logic [7:0] v);
    check(tag, (idx < q.size()) ? 64'(q[idx]) : 64'hDEAD, 64'(v));
  endtask

  function automatic int total_push();
    int s = 0;
    for (int i = 0; i < CC; i++) s += push_cnt[i];
    return s;
  endfunction

  initial begin
    int lat;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_tx_valid", 64'(tx_valid_o), 0);
    check("rst_depth", 64'(req_depth_o), 0);
    check("rst_ids", 64'(|id_o), 0);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // ECHO
    q.delete(); send_byte(8'h01); send_byte(8'h7F);
    wait_tx("echo1_cnt", 2);
    exp_tx("echo1_data", 0, 8'h80); exp_tx("echo1_stat", 1, 8'h00);
    q.delete(); send_byte(8'h01); send_byte(8'hFF);
    wait_tx("echo2_cnt", 2);
    exp_tx("echo2_data", 0, 8'h00); exp_tx("echo2_stat", 1, 8'h00);

    // WR to core 3
    q.delete(); send_byte(8'h04); send_byte(8'h03); send_byte(8'h11); send_byte(8'h0F);
    wait_tx("wr_cnt", 1);
    exp_tx("wr_stat", 0, 8'h00);
    check("wr_id3", 64'(id_o[3]), 64'h11);
    check("wr_len3", 64'(axlen_o[3]), 64'h0F);
    check("wr_write", 64'(write_o), 64'h0008);
    check("wr_push3", 64'(push_cnt[3]), 1);
    check("wr_push_total", 64'(total_push()), 1);
    check("wr_push_id_visible", 64'(push_id3), 64'h11);

    // DEPTH and START
    q.delete(); send_byte(8'h02); send_byte(8'h20);
    wait_tx("depth_cnt", 1);
    exp_tx("depth_stat", 0, 8'h00);
    check("depth_val", 64'(req_depth_o), 64'h20);
    q.delete(); send_byte(8'h06);
    wait_tx("start_cnt_tx", 1);
    exp_tx("start_stat", 0, 8'h00);
    check("start_pulses", 64'(start_cnt), 1);

    // Range error, sticky flag, unknown opcode
    q.delete(); send_byte(8'h07); send_byte(8'h10); send_byte(8'h02);
    wait_tx("range_cnt", 1);
    exp_tx("range_stat", 0, 8'hE2);
    check("range_pmu_addr", 64'(|pmu_addr_o), 0);
    q.delete(); send_byte(8'h08);
    wait_tx("status1_cnt", 2);
    exp_tx("status1_data", 0, 8'h82); exp_tx("status1_stat", 1, 8'h00);
    q.delete(); send_byte(8'h08);
    wait_tx("status2_cnt", 2);
    exp_tx("status2_cleared", 0, 8'h00);
    q.delete(); send_byte(8'h5A);
    wait_tx("unk_cnt", 1);
    exp_tx("unk_stat", 0, 8'hE1);

    // PMU with a mid-stream stall
    pmu_data_i[2] = 64'h0807060504030201;
    q.delete(); send_byte(8'h07); send_byte(8'h02); send_byte(8'h04);
    for (int c = 0; c < 200 && q.size() < 3; c++) @(negedge clk_i);
    tx_ready_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("pmu_stall_hold", 64'(q.size()), 3);
    check("pmu_stall_valid", 64'(tx_valid_o), 1);
    tx_ready_i = 1'b1;
    wait_tx("pmu_cnt", 9);
    for (int i = 0; i < 8; i++) exp_tx($sformatf("pmu_byte%0d", i), i, 8'(i + 1));
    exp_tx("pmu_stat", 8, 8'h00);
    check("pmu_addr2", 64'(pmu_addr_o[2]), 4);

    // Timeout
    q.delete(); send_byte(8'h03); send_byte(8'h01);
    lat = 0;
    while (q.size() == 0 && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check("tmo_window", 64'(lat >= 45 && lat <= 60), 1);
    exp_tx("tmo_stat", 0, 8'hE3);
    check("tmo_no_push", 64'(total_push()), 1);

    // IDLE_STAT
    idle_i = 16'hA5C3;
    q.delete(); send_byte(8'h05);
    wait_tx("istat_cnt", 3);
    exp_tx("istat_b0", 0, 8'hC3); exp_tx("istat_b1", 1, 8'hA5); exp_tx("istat_stat", 2, 8'h00);

    // Reset during PMU data phase
    tx_ready_i = 1'b0;
    q.delete(); send_byte(8'h07); send_byte(8'h02); send_byte(8'h04);
    for (int c = 0; c < 50 && !tx_valid_o; c++) @(negedge clk_i);
    check("rst_mid_valid_pre", 64'(tx_valid_o), 1);
    arstn_i = 1'b0;
    #1;
    check("rst_mid_tx_valid", 64'(tx_valid_o), 0);
    check("rst_mid_busy", 64'(busy_o), 0);
    check("rst_mid_outs", 64'(|{pmu_addr_o, id_o, axlen_o, write_o, req_depth_o, tx_data_o}), 0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    tx_ready_i = 1'b1;
    for (int i = 0; i < CC; i++) push_cnt[i] = 0;
    start_cnt = 0;
    repeat (20) @(negedge clk_i);
    check("rst_mid_no_tx", 64'(q.size()), 0);
    check("rst_mid_no_strobe", 64'(total_push() + start_cnt), 0);
    q.delete(); send_byte(8'h01); send_byte(8'h10);
    wait_tx("echo3_cnt", 2);
    exp_tx("echo3_data", 0, 8'h11); exp_tx("echo3_stat", 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_engine.md
UART_CMD_ENGINE -- requirements
Module: uart_cmd_engine

Interface
REQ-001 SHALL have parameter CORE_COUNT, default 16, number of AXI generator/PMU channels (any value 2..256).
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 5, AXI ID width per channel.
REQ-003 SHALL have parameter PMU_ADDR_WIDTH, default 5, PMU metric select width.
REQ-004 SHALL have parameter PMU_DATA_BYTES, default 8, PMU metric width in bytes (1..8).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, inter-byte argument timeout; 0 disables it.
REQ-006 SHALL derive CORE_BYTES = ceil(clog2(CORE_COUNT)/8), ID_BYTES = ceil(AXI_ID_WIDTH/8) and IDLE_BYTES = ceil(CORE_COUNT/8).
REQ-007 SHALL have the following ports; reset arstn_i is asynchronous, active-low, and the clock is clk_i:
- clk_i  in  1  clock
- arstn_i  in  1  async active-low reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  transmitter accepts byte
- pmu_addr_o  out  [CORE_COUNT][PMU_ADDR_WIDTH]  metric select per channel
- pmu_data_i  in  [CORE_COUNT][8*PMU_DATA_BYTES]  metric value per channel
- req_depth_o  out  8  global request depth
- id_o  out  [CORE_COUNT][AXI_ID_WIDTH]  per-channel AXI ID
- axlen_o  out  [CORE_COUNT][8]  per-channel AXLEN
- write_o  out  [CORE_COUNT][1]  per-channel direction (1 = write)
- fifo_push_o  out  [CORE_COUNT][1]  one-cycle push strobe
- start_o  out  1  one-cycle global start strobe
- idle_i  in  [CORE_COUNT][1]  channel idle
- busy_o  out  1  engine not in IDLE

Function
REQ-008 SHALL implement an FSM with states IDLE, ARGS, EXEC, SEND_DATA, SEND_STATUS; busy_o = (state != IDLE).
REQ-009 In IDLE, an rx byte SHALL be taken as the opcode: 0x01 ECHO(1 arg), 0x02 DEPTH(1), 0x03 RD(CORE_BYTES+ID_BYTES+1), 0x04 WR(same), 0x05 IDLE_STAT(0), 0x06 START(0), 0x07 PMU(CORE_BYTES+1), 0x08 STATUS(0).
REQ-010 An unknown opcode SHALL go to SEND_STATUS with code 0xE1; zero-arg opcodes SHALL go to EXEC; others SHALL go to ARGS.
REQ-011 Multi-byte argument fields SHALL be little-endian; core-index bits above clog2(CORE_COUNT) SHALL be kept for the range check.
REQ-012 ARGS SHALL leave for EXEC the cycle after the last argument byte arrives.
REQ-013 In ARGS, a cycle counter SHALL reset on each rx byte; on reaching TIMEOUT_CYCLES it SHALL go to SEND_STATUS with code 0xE3 and no side effects.
REQ-014 rx bytes arriving in EXEC, SEND_DATA or SEND_STATUS SHALL be dropped.
REQ-015 EXEC, core index >= CORE_COUNT (RD/WR/PMU): no side effect; SEND_STATUS with 0xE2.
REQ-016 EXEC, RD/WR: update id_o, axlen_o and write_o of the selected core, then pulse fifo_push_o[core] for exactly one cycle, while the new values are already visible on the outputs; then SEND_STATUS with 0x00.
REQ-017 EXEC, DEPTH: update req_depth_o; EXEC, START: pulse start_o for exactly one cycle; both then SEND_STATUS with 0x00.
REQ-018 EXEC, ECHO: queue 1 data byte = arg+1, mod 256.
REQ-019 EXEC, IDLE_STAT: snapshot idle_i into IDLE_BYTES bytes, bit i = core i, LSB first, unused bits 0.
REQ-020 EXEC, STATUS: queue 1 byte = {sticky error flag, 3'b0, last status code low nibble}.
REQ-021 EXEC, PMU: drive pmu_addr_o[core]; wait exactly one cycle; register pmu_data_i[core]; queue PMU_DATA_BYTES bytes, LSB first.
REQ-022 After ECHO, IDLE_STAT, STATUS or PMU, EXEC SHALL go to SEND_DATA, then to SEND_STATUS with 0x00.
REQ-023 Each tx byte SHALL use a valid/ready handshake: hold tx_data_o and tx_valid_o stable until tx_ready_i; the byte transfers on the cycle both are high.
REQ-024 A new tx byte MAY be presented the cycle after a transfer.
REQ-025 SEND_STATUS SHALL send exactly one status byte, then return to IDLE.
REQ-026 Every command SHALL terminate with exactly one status byte.
REQ-027 Any non-zero status SHALL set a sticky error flag, cleared only by a STATUS read or by reset.
REQ-028 pmu_addr_o, id_o, axlen_o, write_o and req_depth_o SHALL retain their values between commands.

Reset
REQ-029 On arstn_i low, the FSM SHALL go to IDLE asynchronously.
REQ-030 On arstn_i low, all outputs, counters, snapshot/data registers and the error flag SHALL reset to 0; tx_valid_o = 0 immediately.
REQ-031 A reset mid-command SHALL abandon the command: no strobe and no further tx byte after release.

Verification
REQ-032 ECHO: rx 0x01,0x7F -> tx 0x80,0x00; rx 0x01,0xFF -> tx 0x00,0x00.
REQ-033 WR: rx 0x04,0x03,0x11,0x0F -> id_o[3]=0x11, axlen_o[3]=0x0F, write_o[3]=1, single fifo_push_o[3] pulse, tx 0x00.
REQ-034 Range and opcode errors: rx 0x07,0x10,0x02 (CORE_COUNT=16) -> tx 0xE2 only, pmu_addr_o unchanged; rx 0x08 -> tx 0x82, then flag cleared; rx 0x5A -> tx 0xE1.
REQ-035 PMU: pmu_data_i[2]=0x0807060504030201 after rx 0x07,0x02,0x04 -> pmu_addr_o[2]=4, tx 01..08 then 0x00; tx_ready_i held low 10 cycles mid-stream -> no byte lost or duplicated.
REQ-036 Timeout (TIMEOUT_CYCLES=50): rx 0x03,0x01 then silence -> tx 0xE3 after 50 cycles, no fifo_push_o; IDLE_STAT with idle_i=0xA5C3 -> tx 0xC3,0xA5,0x00.
REQ-037 Reset: arstn_i asserted during PMU SEND_DATA -> tx_valid_o=0, busy_o=0, all outputs 0; a subsequent ECHO works normally.
